// File: rtl/tohost_monitor.sv
// Terminates the riscv-tests "tohost" protocol on the data-memory bus: decodes
// the completion store into pass/fail/error, counts cycles and flags a timeout.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] FROMHOST_ADDR  = 32'h0000_1040,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             dmem_we,
  input  logic             dmem_re,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic [3:0]       dmem_wstrb,
  output logic [31:0]      dmem_rdata,
  output logic             dmem_hit,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             error,
  output logic             timeout,
  output logic [30:0]      test_num,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_ERROR   = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [31:0]       tohost_r, fromhost_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [30:0]       test_num_r, test_num_nxt_s;
  logic [31:0]       rdata_r;
  logic              hit_r;
  logic              done_r, pass_r, fail_r, error_r, timeout_r;

  logic              to_hit_s, fr_hit_s, to_wr_s, fr_wr_s, rd_hit_s;
  logic [31:0]       to_merged_s;
  logic              unused_s;

  assign to_hit_s    = (dmem_addr[31:2] == TOHOST_ADDR[31:2]);
  assign fr_hit_s    = (dmem_addr[31:2] == FROMHOST_ADDR[31:2]);
  assign to_wr_s     = dmem_we & to_hit_s;
  assign fr_wr_s     = dmem_we & fr_hit_s;
  assign rd_hit_s    = dmem_re & (to_hit_s | fr_hit_s);
  assign to_merged_s = merge_bytes(tohost_r, dmem_wdata, dmem_wstrb);
  assign unused_s    = ^dmem_addr[1:0];

  // Next-state decode; a terminal store on the timeout edge takes priority.
  always_comb begin
    state_nxt_s    = state_r;
    test_num_nxt_s = test_num_r;
    case (state_r)
      ST_RUN: begin
        if (to_wr_s && (to_merged_s != 32'd0)) begin
          if (to_merged_s == 32'd1) begin
            state_nxt_s = ST_PASS;
          end else if (to_merged_s[0]) begin
            state_nxt_s    = ST_FAIL;
            test_num_nxt_s = to_merged_s[31:1];
          end else begin
            state_nxt_s = ST_ERROR;
          end
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = ST_TIMEOUT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = state_r;
      end
    endcase
  end

  // State, status flags and saturating cycle counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_RUN;
      cnt_r      <= {CNT_W{1'b0}};
      test_num_r <= 31'd0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      error_r    <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      test_num_r <= test_num_nxt_s;
      if ((state_r == ST_RUN) && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      done_r    <= (state_nxt_s != ST_RUN);
      pass_r    <= (state_nxt_s == ST_PASS);
      fail_r    <= (state_nxt_s == ST_FAIL);
      error_r   <= (state_nxt_s == ST_ERROR) || (state_nxt_s == ST_TIMEOUT);
      timeout_r <= (state_nxt_s == ST_TIMEOUT);
    end
  end

  // Register storage; writes continue after the test has ended.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tohost_r   <= 32'd0;
      fromhost_r <= 32'd0;
    end else begin
      if (to_wr_s) tohost_r <= to_merged_s;
      else         tohost_r <= tohost_r;
      if (fr_wr_s) fromhost_r <= merge_bytes(fromhost_r, dmem_wdata, dmem_wstrb);
      else         fromhost_r <= fromhost_r;
    end
  end

  // Load path samples pre-store values, so same-cycle store is not forwarded.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_r <= 32'd0;
      hit_r   <= 1'b0;
    end else if (rd_hit_s) begin
      rdata_r <= to_hit_s ? tohost_r : fromhost_r;
      hit_r   <= 1'b1;
    end else begin
      rdata_r <= 32'd0;
      hit_r   <= 1'b0;
    end
  end

  assign dmem_rdata  = rdata_r;
  assign dmem_hit    = hit_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign fail        = fail_r;
  assign error       = error_r;
  assign timeout     = timeout_r;
  assign test_num    = test_num_r;
  assign cycle_count = cnt_r;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: one default instance and one with a short
// timeout, sharing the bus but reset independently.
module tb_tohost_monitor;

  logic        clk;
  logic        rst_a, rst_b;
  logic        we, re;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;

  logic [31:0] a_rdata, b_rdata;
  logic        a_hit, a_done, a_pass, a_fail, a_error, a_timeout;
  logic        b_hit, b_done, b_pass, b_fail, b_error, b_timeout;
  logic [30:0] a_tnum, b_tnum;
  logic [31:0] a_cnt, b_cnt;

  int errors = 0;
  int checks = 0;

  tohost_monitor dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a), .dmem_we(we), .dmem_re(re),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_wstrb(strb),
    .dmem_rdata(a_rdata), .dmem_hit(a_hit), .done(a_done), .pass(a_pass),
    .fail(a_fail), .error(a_error), .timeout(a_timeout), .test_num(a_tnum),
    .cycle_count(a_cnt)
  );

  tohost_monitor #(.TIMEOUT_CYCLES(20)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b), .dmem_we(we), .dmem_re(re),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_wstrb(strb),
    .dmem_rdata(b_rdata), .dmem_hit(b_hit), .done(b_done), .pass(b_pass),
    .fail(b_fail), .error(b_error), .timeout(b_timeout), .test_num(b_tnum),
    .cycle_count(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle from a negedge; returns at the following negedge.
  task automatic bus(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    we = w; re = r; addr = a; wdata = d; strb = s;
    @(negedge clk);
    we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0; strb = 4'h0;
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    clk = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0; strb = 4'h0;

    #3;
    chk("rst_done",  {31'd0, a_done},  32'd0);
    chk("rst_flags", {27'd0, a_pass, a_fail, a_error, a_timeout, a_hit}, 32'd0);
    chk("rst_tnum",  {1'b0, a_tnum},   32'd0);
    chk("rst_cnt",   a_cnt,            32'd0);
    chk("rst_rdata", a_rdata,          32'd0);

    // 1: pass at edge 50
    @(negedge clk); rst_a = 1'b1;
    repeat (49) @(negedge clk);
    bus(1'b1, 1'b0, 32'h1000, 32'h1, 4'hF);
    chk("t1_done", {31'd0, a_done}, 32'd1);
    chk("t1_pass", {31'd0, a_pass}, 32'd1);
    chk("t1_fail_err", {30'd0, a_fail, a_error}, 32'd0);
    chk("t1_cnt", a_cnt, 32'd50);
    repeat (1000) @(negedge clk);
    chk("t1_pass_hold", {31'd0, a_pass}, 32'd1);
    chk("t1_cnt_frozen", a_cnt, 32'd50);

    // 2: fail with test number, later pass store ignored
    reset_a();
    bus(1'b1, 1'b0, 32'h1000, 32'h7, 4'hF);
    chk("t2_fail", {30'd0, a_done, a_fail}, 32'd3);
    chk("t2_tnum", {1'b0, a_tnum}, 32'd3);
    chk("t2_pass0", {31'd0, a_pass}, 32'd0);
    bus(1'b1, 1'b0, 32'h1000, 32'h1, 4'hF);
    chk("t2_sticky", {29'd0, a_pass, a_fail, a_done}, 32'd3);
    chk("t2_tnum_hold", {1'b0, a_tnum}, 32'd3);

    // 3a: even nonzero value is an error, not a timeout
    reset_a();
    bus(1'b1, 1'b0, 32'h1000, 32'h4, 4'hF);
    chk("t3_error", {29'd0, a_done, a_error, a_timeout}, 32'd6);
    chk("t3_tnum0", {1'b0, a_tnum}, 32'd0);

    // 4: fromhost byte store and loads
    reset_a();
    bus(1'b1, 1'b0, 32'h1040, 32'h0000_00A5, 4'h1);
    bus(1'b0, 1'b1, 32'h1042, 32'd0, 4'h0);
    chk("t4_fh_hit", {31'd0, a_hit}, 32'd1);
    chk("t4_fh_rdata", a_rdata, 32'h0000_00A5);
    bus(1'b0, 1'b1, 32'h1000, 32'd0, 4'h0);
    chk("t4_th_hit", {31'd0, a_hit}, 32'd1);
    chk("t4_th_rdata", a_rdata, 32'd0);
    bus(1'b0, 1'b1, 32'h2000, 32'd0, 4'h0);
    chk("t4_miss_hit", {31'd0, a_hit}, 32'd0);
    chk("t4_miss_rdata", a_rdata, 32'd0);
    chk("t4_run", {31'd0, a_done}, 32'd0);

    // 5: strobed byte store passes; same-cycle load returns the old value
    reset_a();
    bus(1'b1, 1'b0, 32'h1000, 32'hDEAD_BE01, 4'h1);
    chk("t5_pass", {31'd0, a_pass}, 32'd1);
    bus(1'b1, 1'b1, 32'h1000, 32'h5, 4'hF);
    chk("t5_raw_old", a_rdata, 32'h1);
    chk("t5_still_pass", {30'd0, a_pass, a_fail}, 32'd2);
    bus(1'b0, 1'b1, 32'h1000, 32'd0, 4'h0);
    chk("t5_raw_new", a_rdata, 32'h5);

    // 6: asynchronous reset while in FAIL
    reset_a();
    bus(1'b1, 1'b0, 32'h1000, 32'h7, 4'hF);
    chk("t6_fail", {31'd0, a_fail}, 32'd1);
    @(posedge clk); #2 rst_a = 1'b0; #1;
    chk("t6_flags0", {26'd0, a_done, a_pass, a_fail, a_error, a_timeout, a_hit}, 32'd0);
    chk("t6_tnum0", {1'b0, a_tnum}, 32'd0);
    chk("t6_cnt0", a_cnt, 32'd0);
    @(negedge clk); rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_restart_cnt", a_cnt, 32'd3);
    chk("t6_restart_run", {31'd0, a_done}, 32'd0);

    // 3b: timeout with TIMEOUT_CYCLES=20
    rst_a = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    repeat (19) @(negedge clk);
    chk("t3b_pre_to", {31'd0, b_timeout}, 32'd0);
    chk("t3b_pre_cnt", b_cnt, 32'd19);
    @(negedge clk);
    chk("t3b_to", {28'd0, b_done, b_error, b_timeout, b_pass}, 32'hE);
    repeat (5) @(negedge clk);
    chk("t3b_cnt_frozen", b_cnt, 32'd20);

    // 3c: pass store on the timeout edge wins
    rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    repeat (19) @(negedge clk);
    bus(1'b1, 1'b0, 32'h1000, 32'h1, 4'hF);
    chk("t3c_pass", {28'd0, b_done, b_pass, b_error, b_timeout}, 32'hC);
    chk("t3c_cnt", b_cnt, 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
